// File: rtl/scoreboard_pkg.sv
// Shared definitions for the register-hazard scoreboard.
//   DEF_NUM_REGS / DEF_PEND_W / DEF_RIDX_W : default geometry
//   reg_idx_t  : architectural register index at default geometry
//   pend_cnt_t : pending-write counter at default geometry
//   cnt_max()  : saturation value of a counter of a given width
package scoreboard_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_PEND_W   = 2;
  localparam int DEF_RIDX_W   = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_RIDX_W-1:0] reg_idx_t;
  typedef logic [DEF_PEND_W-1:0] pend_cnt_t;

  function automatic int cnt_max(input int pend_w);
    return (1 << pend_w) - 1;
  endfunction

endpackage

// File: rtl/scoreboard_tracker_counter.sv
// sb_pend_counter: saturating net up/down pending-write counter for one register.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_inc                   : a tracked write to this register issued
//   i_dec_wb, i_dec_kill    : a write retired / a tracked write squashed
//   o_cnt                   : current count
//   o_nonzero, o_at_max, o_one : flags on the current count
//   o_nonzero_d             : next-state count is nonzero
//   o_underflow, o_overflow : this cycle's net update left the legal range
module sb_pend_counter
  import scoreboard_pkg::*;
#(
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_inc,
  input  logic              i_dec_wb,
  input  logic              i_dec_kill,
  output logic [PEND_W-1:0] o_cnt,
  output logic              o_nonzero,
  output logic              o_at_max,
  output logic              o_one,
  output logic              o_nonzero_d,
  output logic              o_underflow,
  output logic              o_overflow
);

  localparam int              SW  = PEND_W + 2;
  localparam logic [PEND_W-1:0] MAX = PEND_W'(cnt_max(PEND_W));

  logic [PEND_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]     sum;

  // Two guard bits: the net result spans -2 .. MAX+1. The top bit flags a
  // negative result, bit PEND_W (with top bit clear) flags MAX+1.
  always_comb begin
    sum         = {2'b00, cnt_q} + SW'(i_inc) - SW'(i_dec_wb) - SW'(i_dec_kill);
    o_underflow = sum[SW-1];
    o_overflow  = !sum[SW-1] && sum[PEND_W];
    cnt_d       = sum[PEND_W-1:0];
    if (o_underflow)     cnt_d = '0;
    else if (o_overflow) cnt_d = MAX;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_cnt       = cnt_q;
  assign o_nonzero   = (cnt_q != '0);
  assign o_at_max    = (cnt_q == MAX);
  assign o_one       = (cnt_q == PEND_W'(1));
  assign o_nonzero_d = (cnt_d != '0);

endmodule

// File: rtl/scoreboard_tracker.sv
// scoreboard_tracker: per-register pending-write scoreboard gating issue.
//   Handshake: o_issue_rdy depends only on the presented instruction fields,
//   the writeback port and counter state, never on i_issue_vld; an
//   instruction is accepted in a cycle where i_issue_vld && o_issue_rdy.
//   i_issue_vld, i_rs1/_used, i_rs2/_used, i_rd/_we : decode instruction
//   o_issue_rdy                : no source or structural hazard
//   i_wb_vld, i_wb_rd          : retiring write
//   i_kill_vld, i_kill_rd      : squashed tracked write
//   o_busy_cnt, o_empty        : registered occupancy summary
//   o_err                      : sticky underflow/overflow error
module scoreboard_tracker
  import scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int PEND_W    = DEF_PEND_W,
  parameter bit WB_BYPASS = 1'b0,
  localparam int RIDX_W   = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_issue_vld,
  input  logic [RIDX_W-1:0] i_rs1,
  input  logic              i_rs1_used,
  input  logic [RIDX_W-1:0] i_rs2,
  input  logic              i_rs2_used,
  input  logic [RIDX_W-1:0] i_rd,
  input  logic              i_rd_we,
  output logic              o_issue_rdy,
  input  logic              i_wb_vld,
  input  logic [RIDX_W-1:0] i_wb_rd,
  input  logic              i_kill_vld,
  input  logic [RIDX_W-1:0] i_kill_rd,
  output logic [RIDX_W:0]   o_busy_cnt,
  output logic              o_empty,
  output logic              o_err
);

  logic [NUM_REGS-1:0] inc_v, dec_wb_v, dec_kill_v;
  logic [NUM_REGS-1:0] nz_w, at_max_w, one_w, nz_next_w, unf_w, ovf_w;
  logic [PEND_W-1:0]   cnt_w [NUM_REGS];

  logic haz1, haz2, struct_stall, issue_fire;
  logic [RIDX_W:0] busy_d, busy_q;
  logic            empty_q, err_q, err_d;
  logic            unused_cnt;

  // Register 0 is hard-wired zero: no counter, every flag tied low, so it
  // never stalls and wb/kill to it are simply dropped.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign cnt_w[r]     = '0;
      assign nz_w[r]      = 1'b0;
      assign at_max_w[r]  = 1'b0;
      assign one_w[r]     = 1'b0;
      assign nz_next_w[r] = 1'b0;
      assign unf_w[r]     = 1'b0;
      assign ovf_w[r]     = 1'b0;
    end else begin : g_cnt
      sb_pend_counter #(.PEND_W(PEND_W)) u_cnt (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_inc       (inc_v[r]),
        .i_dec_wb    (dec_wb_v[r]),
        .i_dec_kill  (dec_kill_v[r]),
        .o_cnt       (cnt_w[r]),
        .o_nonzero   (nz_w[r]),
        .o_at_max    (at_max_w[r]),
        .o_one       (one_w[r]),
        .o_nonzero_d (nz_next_w[r]),
        .o_underflow (unf_w[r]),
        .o_overflow  (ovf_w[r])
      );
    end
  end

  // A source whose last pending write retires this cycle is released early
  // only in bypass mode (write-through register file). Kills never bypass.
  always_comb begin
    haz1 = i_rs1_used && nz_w[i_rs1] &&
           !(WB_BYPASS && i_wb_vld && (i_wb_rd == i_rs1) && one_w[i_rs1]);
    haz2 = i_rs2_used && nz_w[i_rs2] &&
           !(WB_BYPASS && i_wb_vld && (i_wb_rd == i_rs2) && one_w[i_rs2]);
    struct_stall = i_rd_we && at_max_w[i_rd];
    o_issue_rdy  = !(haz1 || haz2 || struct_stall);
    issue_fire   = i_issue_vld && o_issue_rdy;
  end

  always_comb begin
    inc_v      = '0;
    dec_wb_v   = '0;
    dec_kill_v = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_v[r]      = issue_fire && i_rd_we && (i_rd == RIDX_W'(r));
      dec_wb_v[r]   = i_wb_vld   && (i_wb_rd   == RIDX_W'(r));
      dec_kill_v[r] = i_kill_vld && (i_kill_rd == RIDX_W'(r));
    end
  end

  // Counter values are kept for debug visibility; only the flags drive logic.
  always_comb begin
    unused_cnt = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) unused_cnt = unused_cnt ^ (^cnt_w[r]);
  end

  // Occupancy is taken from next-state counts so the registered summary
  // lines up with the counters one cycle after the update.
  always_comb begin
    busy_d = '0;
    for (int r = 0; r < NUM_REGS; r++) busy_d = busy_d + (RIDX_W+1)'(nz_next_w[r]);
    err_d = err_q || (|unf_w) || (|ovf_w);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q  <= '0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      empty_q <= (busy_d == '0);
      err_q   <= err_d;
    end
  end

  assign o_busy_cnt = busy_q;
  assign o_empty    = empty_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_scoreboard_tracker.sv
module tb_scoreboard_tracker;

  localparam int RW = 5;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_issue_vld, i_rs1_used, i_rs2_used, i_rd_we;
  logic [RW-1:0] i_rs1, i_rs2, i_rd;
  logic          i_wb_vld, i_kill_vld;
  logic [RW-1:0] i_wb_rd, i_kill_rd;

  logic          rdy, empty, err;
  logic [RW:0]   busy;
  logic          rdy_bp, empty_bp, err_bp;
  logic [RW:0]   busy_bp;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset block
  always #5 i_clk = ~i_clk;

  scoreboard_tracker #(.NUM_REGS(32), .PEND_W(2), .WB_BYPASS(1'b0)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_issue_vld(i_issue_vld),
    .i_rs1(i_rs1), .i_rs1_used(i_rs1_used), .i_rs2(i_rs2), .i_rs2_used(i_rs2_used),
    .i_rd(i_rd), .i_rd_we(i_rd_we), .o_issue_rdy(rdy),
    .i_wb_vld(i_wb_vld), .i_wb_rd(i_wb_rd), .i_kill_vld(i_kill_vld), .i_kill_rd(i_kill_rd),
    .o_busy_cnt(busy), .o_empty(empty), .o_err(err)
  );

  // Bypass variant driven by the same stimulus, checked only until its state diverges.
  scoreboard_tracker #(.NUM_REGS(32), .PEND_W(2), .WB_BYPASS(1'b1)) dut_bp (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_issue_vld(i_issue_vld),
    .i_rs1(i_rs1), .i_rs1_used(i_rs1_used), .i_rs2(i_rs2), .i_rs2_used(i_rs2_used),
    .i_rd(i_rd), .i_rd_we(i_rd_we), .o_issue_rdy(rdy_bp),
    .i_wb_vld(i_wb_vld), .i_wb_rd(i_wb_rd), .i_kill_vld(i_kill_vld), .i_kill_rd(i_kill_rd),
    .o_busy_cnt(busy_bp), .o_empty(empty_bp), .o_err(err_bp)
  );

  // driver tasks
  task automatic idle();
    i_issue_vld = 0; i_rs1 = '0; i_rs1_used = 0; i_rs2 = '0; i_rs2_used = 0;
    i_rd = '0; i_rd_we = 0; i_wb_vld = 0; i_wb_rd = '0; i_kill_vld = 0; i_kill_rd = '0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [RW-1:0] rd, input logic [RW-1:0] rs1, input logic rs1_used);
    i_issue_vld = 1; i_rd = rd; i_rd_we = 1; i_rs1 = rs1; i_rs1_used = rs1_used;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    i_rst_n = 0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy_bp", 32'(busy_bp), 0);
    chk("rst_empty_bp", 32'(empty_bp), 1);
    chk("rst_err_bp", 32'(err_bp), 0);
    i_rst_n = 1;
    tick();

    // issue add x5
    issue(5'd5, 5'd0, 0);
    #1 chk("x5_issue_rdy", 32'(rdy), 1);
    tick();
    idle();
    chk("x5_busy", 32'(busy), 1);
    chk("x5_empty", 32'(empty), 0);

    // RAW on x5
    issue(5'd6, 5'd5, 1);
    #1 chk("raw_rdy", 32'(rdy), 0);
    chk("raw_rdy_bp", 32'(rdy_bp), 0);
    tick();
    i_wb_vld = 1; i_wb_rd = 5'd5;
    #1 chk("raw_wb_rdy", 32'(rdy), 0);
    chk("raw_wb_rdy_bp", 32'(rdy_bp), 1);
    tick();
    i_wb_vld = 0;
    #1 chk("raw_after_wb_rdy", 32'(rdy), 1);
    i_issue_vld = 0;
    chk("raw_after_wb_busy", 32'(busy), 0);
    chk("raw_after_wb_empty", 32'(empty), 1);
    idle();

    // structural stall on x7
    for (int k = 0; k < 3; k++) begin
      issue(5'd7, 5'd0, 0);
      #1 chk($sformatf("x7_w%0d_rdy", k), 32'(rdy), 1);
      tick();
    end
    #1 chk("x7_4th_rdy", 32'(rdy), 0);
    chk("x7_busy", 32'(busy), 1);
    tick();
    i_wb_vld = 1; i_wb_rd = 5'd7;
    #1 chk("x7_4th_wb_rdy", 32'(rdy), 0);
    tick();
    i_wb_vld = 0;
    #1 chk("x7_after_wb_rdy", 32'(rdy), 1);
    idle();
    i_wb_vld = 1; i_wb_rd = 5'd7;
    tick();
    tick();
    idle();
    chk("x7_drain_busy", 32'(busy), 0);
    chk("x7_drain_err", 32'(err), 0);

    // same-cycle issue/wb/kill on x9
    issue(5'd9, 5'd0, 0);
    tick();
    issue(5'd9, 5'd0, 0);
    i_wb_vld = 1; i_wb_rd = 5'd9;
    #1 chk("x9_iw_rdy", 32'(rdy), 1);
    tick();
    idle();
    chk("x9_iw_busy", 32'(busy), 1);
    chk("x9_iw_err", 32'(err), 0);
    i_rs1 = 5'd9; i_rs1_used = 1;
    #1 chk("x9_still_pending", 32'(rdy), 0);
    idle();
    issue(5'd9, 5'd0, 0);
    i_wb_vld = 1; i_wb_rd = 5'd9; i_kill_vld = 1; i_kill_rd = 5'd9;
    #1 chk("x9_iwk_rdy", 32'(rdy), 1);
    tick();
    idle();
    chk("x9_iwk_empty", 32'(empty), 1);
    chk("x9_iwk_busy", 32'(busy), 0);
    chk("x9_iwk_err", 32'(err), 0);

    // x0 only
    i_issue_vld = 1; i_rs1_used = 1; i_rs2_used = 1; i_rd_we = 1;
    #1 chk("x0_rdy0", 32'(rdy), 1);
    tick();
    chk("x0_rdy1", 32'(rdy), 1);
    tick();
    idle();
    chk("x0_busy", 32'(busy), 0);
    i_wb_vld = 1; i_wb_rd = 5'd0;
    tick();
    idle();
    chk("x0_wb_err", 32'(err), 0);

    // underflow on x12
    i_wb_vld = 1; i_wb_rd = 5'd12;
    tick();
    idle();
    chk("x12_err", 32'(err), 1);
    chk("x12_empty", 32'(empty), 1);
    tick();
    chk("x12_err_sticky", 32'(err), 1);

    // mid-operation async reset with cnt[3]=2
    issue(5'd3, 5'd0, 0);
    tick();
    tick();
    idle();
    chk("x3_busy", 32'(busy), 1);
    #2 i_rst_n = 0;
    #1 chk("arst_busy", 32'(busy), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_err", 32'(err), 0);
    i_rs1 = 5'd3; i_rs1_used = 1;
    #1 chk("arst_x3_rdy", 32'(rdy), 1);
    idle();
    tick();
    i_rst_n = 1;
    tick();
    // stale writeback after reset
    i_wb_vld = 1; i_wb_rd = 5'd3;
    tick();
    idle();
    chk("stale_wb_err", 32'(err), 1);
    chk("stale_wb_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scoreboard_tracker.md
Name: scoreboard_tracker

Overview:
- Parametrised register-hazard scoreboard for the in-order, non-forwarding RISC-V pipeline; successor to the single-bit-per-register busy scoreboard.
- Keeps a saturating pending-write counter per architectural register, so several writes to one rd can be in flight at once.
- Sits between decode/issue and writeback. Gates issue with a valid/ready handshake and is told about writebacks and squashed (killed) instructions.
- Optional writeback bypass mode releases a hazard in the same cycle as the register-file write.

Parameters:
- NUM_REGS, 32, number of architectural registers; index 0 is hard-wired zero and never tracked.
- PEND_W, 2, width of each pending counter; at most 2^PEND_W-1 outstanding writes per register.
- WB_BYPASS, 0, 1 = a same-cycle writeback that drops a source's count to 0 clears that source's hazard combinationally (register file is write-through). 0 = hazard clears the cycle after.
- RIDX_W (localparam), $clog2(NUM_REGS), register index width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_issue_vld  in  1  decode presents an instruction
- i_rs1  in  RIDX_W  source 1 index
- i_rs1_used  in  1  instruction reads rs1
- i_rs2  in  RIDX_W  source 2 index
- i_rs2_used  in  1  instruction reads rs2
- i_rd  in  RIDX_W  destination index
- i_rd_we  in  1  instruction writes rd
- o_issue_rdy  out  1  no hazard; issue accepted when vld&rdy
- i_wb_vld  in  1  writeback retires a write
- i_wb_rd  in  RIDX_W  writeback destination
- i_kill_vld  in  1  a tracked, squashed instruction will never write back
- i_kill_rd  in  RIDX_W  killed instruction's rd
- o_busy_cnt  out  RIDX_W+1  number of registers with nonzero count (registered)
- o_empty  out  1  all counters zero (registered)
- o_err  out  1  sticky protocol error

Behaviour:
- Reset (async, active-low): all counters 0, o_busy_cnt=0, o_empty=1, o_err=0. o_issue_rdy is combinational, so after reset it is 1 whenever the presented instruction has no hazard.
- Tracked write: issue is accepted (vld&rdy), i_rd_we=1 and i_rd!=0. Accesses to register 0 never stall and are never counted; a wb or kill to register 0 is ignored.
- Hazard: a source hazard exists when that source is used, its index !=0 and cnt[index]!=0.
  - With WB_BYPASS=1, a source is exempt when i_wb_vld, i_wb_rd==index and cnt[index]==1.
  - A kill never bypasses.
- Structural stall: i_rd_we, rd!=0 and cnt[rd]==2^PEND_W-1.
- o_issue_rdy = !(hazard1|hazard2|structural). It is purely combinational from the inputs and counter state; there is no dependence of rdy on vld.
- Counter update per register r each cycle: next = cnt + inc - dec_wb - dec_kill, each term 0/1.
  - inc = tracked issue to r.
  - dec_wb = wb to r.
  - dec_kill = kill to r.
  - Issue, wb and kill may all target the same r in the same cycle; the net result is applied. Example: cnt=1, issue+wb+kill → 0.
- Underflow: when a decrement would make a count negative, the counter holds at 0 and o_err is set. Overflow cannot occur because issue is stalled at saturation.
  - If it is forced anyway (inc with cnt==max and no dec), the counter holds at max and o_err is set.
- o_err stays set until reset.
- o_busy_cnt and o_empty are computed from next-state counts and registered, so they are valid one cycle after the update.
- Reset mid-operation clears all state immediately. In-flight writebacks that arrive after reset decrement from zero, set o_err and the counters stay 0; the pipeline must be flushed together with the reset.
- Latency: issue→source-visible hazard is 1 cycle (the counter is registered). Writeback→hazard release is 1 cycle with WB_BYPASS=0 and 0 cycles with WB_BYPASS=1.

Decomposition:
- Package scoreboard_pkg:
  - localparams: default NUM_REGS, PEND_W and RIDX_W.
  - typedef reg_idx_t (logic [RIDX_W-1:0]).
  - typedef pend_cnt_t (logic [PEND_W-1:0]).
  - function cnt_max().
- Sub-module sb_pend_counter, one instance per register 1..NUM_REGS-1:
  - inputs: inc, dec_wb, dec_kill.
  - outputs: cnt, nonzero, at_max, one, underflow, overflow.
  - saturating net up/down counter with asynchronous reset.
- The top level handles index decode, hazard/ready logic, population count, and error/empty registers.

Test Plan:
- Reset then issue add x5 (rd=5, we) → o_issue_rdy=1. Next cycle cnt[5]=1, o_busy_cnt=1, o_empty=0. Then an instruction reading rs1=5 → rdy=0 until wb_rd=5, after which rdy=1 one cycle later (WB_BYPASS=0), or rdy=1 in the same cycle as the wb (WB_BYPASS=1).
- PEND_W=2: issue three writes to x7 back-to-back → the 4th write to x7 is held at rdy=0 (structural). One wb to x7 → rdy=1 next cycle, cnt[7] 3→2.
- Same cycle: cnt[9]=1, issue rd=9 plus wb rd=9 → cnt[9] stays 1, no o_err. Repeat with an added kill rd=9 → cnt[9]=0, o_empty=1 the following cycle.
- Issue reading/writing x0 only (rs1=0, rs2=0, rd=0) → rdy=1 always, o_busy_cnt stays 0. A wb to x0 → no o_err.
- wb rd=12 while cnt[12]=0 → cnt stays 0 and o_err=1 next cycle, persisting until i_rst_n pulses low. Asserting i_rst_n=0 mid-operation with cnt[3]=2 → counters clear asynchronously, o_empty=1.
